pi_audio_rx: RTL and testbench
==============================

// Module: pi_audio_rx
// PURPOSE
//  Receives 18-bit stereo PCM from the Raspberry Pi over the GPIO_AUDIO/GPIO_ARQ/GPIO_ACL interface.
//  Assembles 6-bit chunks into L/R frames and buffers them in a frame FIFO.
//  Pops one frame per sample_req_i and presents it to spdif_core.sample_i as {L20,R20}.
//  Single clock domain: clk; the Pi-side strobe is asynchronous and is synchronised internally.
// PARAMETERS
//  DEPTH_LOG2  8     FIFO depth = 2**DEPTH_LOG2 frames (36 bits each)
//  SYNC_STAGES 2     synchroniser flops on GPIO_ACL and GPIO_AUDIO (>=2)
//  TIMEOUT     1024  clk cycles without a chunk before a partial frame is discarded
// PORTS
//  clk             in   1   system clock
//  rst_i           in   1   asynchronous reset, active-high
//  GPIO_AUDIO      in   6   audio chunk from Pi, stable while GPIO_ACL high
//  GPIO_ACL        in   1   Pi chunk strobe; rising edge = chunk valid
//  GPIO_ARQ        out  1   FPGA request: FIFO can accept another frame
//  flush_i         in   1   sync clear of FIFO and assembler
//  sample_req_i    in   1   one-cycle pulse at output sample rate
//  sample_o        out  40  {L[17:0],2'b00,R[17:0],2'b00} to spdif_core
//  level_o         out  DEPTH_LOG2+1  frames currently in FIFO
//  overflow_cnt_o  out  8   frames dropped because FIFO full (saturating)
//  underrun_cnt_o  out  8   sample_req_i with FIFO empty (saturating)
//  resync_cnt_o    out  8   partial frames discarded by timeout/flush (saturating)
// BEHAVIOUR
//  Reset: GPIO_ARQ=0, sample_o=0, level_o=0, all counters 0, chunk index 0, FIFO pointers 0.
//  Input sync: GPIO_ACL and GPIO_AUDIO both pass through SYNC_STAGES flops, so data stays aligned to strobe.
//   A chunk is taken when synced ACL goes 0->1; data is the synced GPIO_AUDIO in that same cycle.
//  Chunk order (MSB first): idx0=L[17:12], 1=L[11:6], 2=L[5:0], 3=R[17:12], 4=R[11:6], 5=R[5:0].
//   idx increments per chunk and wraps 5->0.
//  Frame commit: the cycle after chunk idx5 is taken, {L,R} is written if level<DEPTH.
//   If full, the frame is dropped and overflow_cnt_o increments.
//  Timeout: a cycle counter clears on each chunk and counts only while idx!=0.
//   Reaching TIMEOUT sets idx=0, discards partial data, and increments resync_cnt_o.
//  GPIO_ARQ: registered; 1 when level_o < DEPTH-1, so room is left for the frame in flight.
//   The Pi starts a frame only while GPIO_ARQ=1. Deasserting it mid-frame does not abort that frame.
//  Output: on sample_req_i with level>0, pop the head; sample_o updates the next cycle (1-cycle latency).
//   On sample_req_i with level==0: sample_o holds its value and underrun_cnt_o increments.
//  Simultaneous commit and pop: both happen and level is unchanged.
//   A pop with level==0 is never combined with the same-cycle write (no fall-through).
//  Pointers are DEPTH_LOG2 bits and wrap naturally. level_o = writes - pops, range 0..DEPTH.
//  flush_i: pointers, level and idx go to 0. A pending partial frame increments resync_cnt_o.
//   sample_o and the other counters are kept. A chunk arriving in the same cycle as flush_i is discarded.
//  Counters saturate at 255 and are cleared only by rst_i.
//  rst_i mid-frame: everything returns to reset values. The Pi sees GPIO_ARQ=0 and must restart at idx0.
// TESTING
//  1 Send 6 chunks 3F,00,15,2A,01,3E, then pulse sample_req_i -> next cycle sample_o={18'h3F015,2'b0,18'h2A07E,2'b0}.
//  2 Send DEPTH+1 frames with no pops -> level_o=DEPTH, GPIO_ARQ=0 from level DEPTH-1, overflow_cnt_o=1, order intact.
//  3 Pulse sample_req_i on empty FIFO after one popped frame -> sample_o unchanged, underrun_cnt_o=1.
//  4 Send 2 chunks, then idle TIMEOUT cycles, then send a full frame -> resync_cnt_o=1, popped frame equals the full frame.
//  5 Commit a frame in the same cycle as sample_req_i with level=3 -> level stays 3 and the correct head frame is popped.
//  6 Assert rst_i mid-frame, release, send a frame -> all outputs 0 after reset, and the new frame is assembled from idx0.

Source files
------------

// File: rtl/pi_audio_rx.sv
// Raspberry Pi GPIO audio receiver: assembles 6-bit chunks into 18-bit stereo frames,
// buffers them in a frame FIFO and pops one frame per sample request for spdif_core.
module pi_audio_rx #(
    parameter int DEPTH_LOG2  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [5:0]            GPIO_AUDIO,
    input  logic                  GPIO_ACL,
    output logic                  GPIO_ARQ,
    input  logic                  flush_i,
    input  logic                  sample_req_i,
    output logic [39:0]           sample_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [7:0]            overflow_cnt_o,
    output logic [7:0]            underrun_cnt_o,
    output logic [7:0]            resync_cnt_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] acl_sync;
    logic                   acl_prev;
    logic [5:0]             audio_sync [SYNC_STAGES];
    logic [35:0]            frame_acc;
    logic [35:0]            mem [DEPTH];
    logic [2:0]             idx;
    logic [TW-1:0]          tmo_cnt;
    logic                   commit_pend;
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   take;
    logic                   do_write;
    logic                   do_pop;
    logic [LW-1:0]          level_nxt;

    // Stage: synchronisers; data travels through the same depth as the strobe
    always_ff @(posedge clk) begin
        audio_sync[0] <= GPIO_AUDIO;
        for (int i = 1; i < SYNC_STAGES; i++)
            audio_sync[i] <= audio_sync[i-1];
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            acl_sync <= '0;
            acl_prev <= 1'b0;
        end else begin
            acl_sync <= {acl_sync[SYNC_STAGES-2:0], GPIO_ACL};
            acl_prev <= acl_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        take      = acl_sync[SYNC_STAGES-1] & ~acl_prev & ~flush_i;
        do_write  = commit_pend && (level_o != DEPTH_L) && !flush_i;
        do_pop    = sample_req_i && (level_o != '0) && !flush_i;
        level_nxt = level_o + LW'(do_write) - LW'(do_pop);
        if (flush_i)
            level_nxt = '0;
    end

    // Stage: chunk assembly and frame storage (data path, no reset)
    always_ff @(posedge clk) begin
        if (take)
            frame_acc <= {frame_acc[29:0], audio_sync[SYNC_STAGES-1]};
        if (do_write)
            mem[wr_ptr] <= frame_acc;
    end

    // Stage: control, FIFO pointers, output register and status counters
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            idx            <= '0;
            tmo_cnt        <= '0;
            commit_pend    <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level_o        <= '0;
            GPIO_ARQ       <= 1'b0;
            sample_o       <= '0;
            overflow_cnt_o <= '0;
            underrun_cnt_o <= '0;
            resync_cnt_o   <= '0;
        end else begin
            commit_pend <= 1'b0;
            level_o     <= level_nxt;
            GPIO_ARQ    <= (level_nxt < DEPTH_L - LW'(1));

            if (flush_i) begin
                idx     <= '0;
                tmo_cnt <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                if (idx != 3'd0)
                    resync_cnt_o <= sat_inc(resync_cnt_o);
            end else begin
                if (take) begin
                    tmo_cnt <= '0;
                    if (idx == 3'd5) begin
                        idx         <= '0;
                        commit_pend <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end else if (idx != 3'd0) begin
                    // A stalled partial frame is abandoned so the next chunk restarts at L[17:12]
                    if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        idx          <= '0;
                        tmo_cnt      <= '0;
                        resync_cnt_o <= sat_inc(resync_cnt_o);
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                if (do_write)
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                else if (commit_pend)
                    overflow_cnt_o <= sat_inc(overflow_cnt_o);

                if (do_pop) begin
                    rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                    sample_o <= {mem[rd_ptr][35:18], 2'b00, mem[rd_ptr][17:0], 2'b00};
                end
            end

            if (sample_req_i && level_o == '0)
                underrun_cnt_o <= sat_inc(underrun_cnt_o);
        end
    end

endmodule

// File: tb/tb_pi_audio_rx.sv
// Directed bench for pi_audio_rx: chunk assembly, FIFO full/empty, timeout, concurrent
// commit/pop, mid-frame reset and flush.
module tb_pi_audio_rx;

    localparam int DL  = 3;
    localparam int DEP = 8;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  GPIO_AUDIO = '0;
    logic        GPIO_ACL = 1'b0;
    logic        GPIO_ARQ;
    logic        flush_i = 1'b0;
    logic        sample_req_i = 1'b0;
    logic [39:0] sample_o;
    logic [DL:0] level_o;
    logic [7:0]  overflow_cnt_o, underrun_cnt_o, resync_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    pi_audio_rx #(.DEPTH_LOG2(DL), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_i(rst_i), .GPIO_AUDIO(GPIO_AUDIO), .GPIO_ACL(GPIO_ACL),
        .GPIO_ARQ(GPIO_ARQ), .flush_i(flush_i), .sample_req_i(sample_req_i),
        .sample_o(sample_o), .level_o(level_o), .overflow_cnt_o(overflow_cnt_o),
        .underrun_cnt_o(underrun_cnt_o), .resync_cnt_o(resync_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chunk(input logic [5:0] d);
        GPIO_AUDIO = d;
        GPIO_ACL   = 1'b1;
        tick(4);
        GPIO_ACL   = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [17:0] l, input logic [17:0] r);
        chunk(l[17:12]); chunk(l[11:6]); chunk(l[5:0]);
        chunk(r[17:12]); chunk(r[11:6]); chunk(r[5:0]);
    endtask

    task automatic pop();
        sample_req_i = 1'b1;
        tick(1);
        sample_req_i = 1'b0;
    endtask

    function automatic logic [39:0] exp_s(input logic [17:0] l, input logic [17:0] r);
        return {l, 2'b00, r, 2'b00};
    endfunction

    function automatic logic [17:0] fl(input int i);
        return 18'h10000 + 18'(i * 7);
    endfunction

    function automatic logic [17:0] fr(input int i);
        return 18'h20500 + 18'(i * 13);
    endfunction

    initial begin
        logic [17:0] dl, dr;
        tick(2);
        check("rst_sample", 64'(sample_o), 64'h0);
        check("rst_level", 64'(level_o), 64'h0);
        check("rst_arq", 64'(GPIO_ARQ), 64'h0);
        check("rst_cnts", {overflow_cnt_o, underrun_cnt_o, resync_cnt_o}, 64'h0);
        rst_i = 1'b0;
        tick(2);
        check("arq_after_rst", 64'(GPIO_ARQ), 64'h1);

        // Test 1: basic chunk assembly
        chunk(6'h3F); chunk(6'h00); chunk(6'h15); chunk(6'h2A); chunk(6'h01); chunk(6'h3E);
        check("t1_level", 64'(level_o), 64'd1);
        pop();
        check("t1_sample", 64'(sample_o), 64'({18'h3F015, 2'b00, 18'h2A07E, 2'b00}));
        check("t1_level_after", 64'(level_o), 64'd0);

        // Test 2: fill beyond depth
        for (int i = 0; i <= DEP; i++) begin
            send_frame(fl(i), fr(i));
            if (i == DEP - 3) check("t2_arq_lvl6", 64'(GPIO_ARQ), 64'h1);
            if (i == DEP - 2) check("t2_arq_lvl7", 64'(GPIO_ARQ), 64'h0);
        end
        check("t2_level_full", 64'(level_o), 64'(DEP));
        check("t2_overflow", 64'(overflow_cnt_o), 64'd1);
        check("t2_arq_full", 64'(GPIO_ARQ), 64'h0);
        for (int i = 0; i < DEP; i++) begin
            pop();
            check($sformatf("t2_order%0d", i), 64'(sample_o), 64'(exp_s(fl(i), fr(i))));
        end
        check("t2_level_empty", 64'(level_o), 64'd0);

        // Test 3: underrun
        pop();
        check("t3_hold", 64'(sample_o), 64'(exp_s(fl(DEP-1), fr(DEP-1))));
        check("t3_underrun", 64'(underrun_cnt_o), 64'd1);

        // Test 4: timeout of a partial frame
        chunk(6'h11); chunk(6'h22);
        tick(TMO + 20);
        check("t4_resync", 64'(resync_cnt_o), 64'd1);
        check("t4_level0", 64'(level_o), 64'd0);
        send_frame(18'h12345, 18'h3ABCD);
        check("t4_level1", 64'(level_o), 64'd1);
        pop();
        check("t4_sample", 64'(sample_o), 64'(exp_s(18'h12345, 18'h3ABCD)));

        // Test 5: commit coincident with pop at level 3
        send_frame(18'h0AAAA, 18'h15555);
        send_frame(18'h0BBBB, 18'h14444);
        send_frame(18'h0CCCC, 18'h13333);
        check("t5_level3", 64'(level_o), 64'd3);
        dl = 18'h0DDDD; dr = 18'h12222;
        chunk(dl[17:12]); chunk(dl[11:6]); chunk(dl[5:0]); chunk(dr[17:12]); chunk(dr[11:6]);
        GPIO_AUDIO = dr[5:0];
        GPIO_ACL   = 1'b1;
        tick(3);
        sample_req_i = 1'b1;
        tick(1);
        sample_req_i = 1'b0;
        check("t5_level_same", 64'(level_o), 64'd3);
        check("t5_head", 64'(sample_o), 64'(exp_s(18'h0AAAA, 18'h15555)));
        GPIO_ACL = 1'b0;
        tick(4);
        check("t5_level_after", 64'(level_o), 64'd3);
        pop(); check("t5_b", 64'(sample_o), 64'(exp_s(18'h0BBBB, 18'h14444)));
        pop(); check("t5_c", 64'(sample_o), 64'(exp_s(18'h0CCCC, 18'h13333)));
        pop(); check("t5_d", 64'(sample_o), 64'(exp_s(dl, dr)));
        check("t5_underrun_kept", 64'(underrun_cnt_o), 64'd1);

        // Test 6: reset mid-frame
        chunk(6'h2B); chunk(6'h1C);
        rst_i = 1'b1;
        tick(2);
        check("t6_sample", 64'(sample_o), 64'h0);
        check("t6_level", 64'(level_o), 64'h0);
        check("t6_arq", 64'(GPIO_ARQ), 64'h0);
        check("t6_cnts", {overflow_cnt_o, underrun_cnt_o, resync_cnt_o}, 64'h0);
        rst_i = 1'b0;
        tick(2);
        send_frame(18'h2468A, 18'h13579);
        check("t6_level1", 64'(level_o), 64'd1);
        pop();
        check("t6_frame", 64'(sample_o), 64'(exp_s(18'h2468A, 18'h13579)));

        // Flush with a pending partial frame and a buffered frame
        send_frame(18'h00F0F, 18'h0F0F0);
        chunk(6'h05);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        tick(1);
        check("fl_level", 64'(level_o), 64'd0);
        check("fl_resync", 64'(resync_cnt_o), 64'd1);
        check("fl_sample_kept", 64'(sample_o), 64'(exp_s(18'h2468A, 18'h13579)));
        send_frame(18'h3FFFF, 18'h00001);
        pop();
        check("fl_next_frame", 64'(sample_o), 64'(exp_s(18'h3FFFF, 18'h00001)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
